// File: rtl/multicycle_sequencer_if.sv
// Memory handshake bundle for the multicycle sequencer.
// Instruction fetch and data access request/ready pairs.
interface multicycle_sequencer_if;
   logic imem_req;
   logic imem_ready;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ready;

   modport master (
      output imem_req,
      output dmem_req,
      output dmem_we,
      input  imem_ready,
      input  dmem_ready
   );

   modport slave (
      input  imem_req,
      input  dmem_req,
      input  dmem_we,
      output imem_ready,
      output dmem_ready
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: fetch/decode/execute/memory/writeback
// with memory-ready timeout, sticky error and retirement counter.
module multicycle_sequencer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                         clock,
   input  logic                         reset,
   multicycle_sequencer_if.master       mem,
   input  logic                         readmem,
   input  logic                         writemem,
   input  logic                         writereg,
   input  logic [1:0]                   selbrjumpz,
   input  logic                         branch_taken,
   output logic                         ir_write,
   output logic                         regfile_write,
   output logic                         pc_write,
   output logic                         pc_sel,
   output logic [2:0]                   state,
   output logic                         error,
   output logic [15:0]                  instr_count
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_RSV5      = 3'd5,
      S_RSV6      = 3'd6,
      S_ERROR     = 3'd7
   } state_e;

   localparam logic [3:0] TMO = 4'(TIMEOUT);

   state_e      state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        wb_q, wb_d;
   logic [1:0]  sel_q, sel_d;
   logic [15:0] count_q, count_d;

   logic imem_req_c;
   logic ir_write_c;
   logic dmem_req_c;
   logic dmem_we_c;
   logic rf_write_c;
   logic pc_write_c;
   logic pc_sel_c;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= 4'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         wb_q    <= 1'b0;
         sel_q   <= 2'd0;
         count_q <= 16'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         wb_q    <= wb_d;
         sel_q   <= sel_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      wb_d       = wb_q;
      sel_d      = sel_q;
      imem_req_c = 1'b0;
      ir_write_c = 1'b0;
      dmem_req_c = 1'b0;
      dmem_we_c  = 1'b0;
      rf_write_c = 1'b0;
      pc_write_c = 1'b0;
      pc_sel_c   = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            imem_req_c = 1'b1;
            if (mem.imem_ready) begin
               ir_write_c = 1'b1;
               state_d    = S_DECODE;
            end else if (wait_q == TMO) begin
               state_d = S_ERROR;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         S_DECODE: begin
            rd_d    = readmem;
            wr_d    = writemem;
            wb_d    = writereg;
            sel_d   = selbrjumpz;
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (sel_q != 2'd0) begin
               pc_write_c = 1'b1;
               pc_sel_c   = branch_taken;
               state_d    = S_FETCH;
            end else if (rd_q || wr_q) begin
               state_d = S_MEMORY;
            end else if (wb_q) begin
               state_d = S_WRITEBACK;
            end else begin
               pc_write_c = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_MEMORY: begin
            dmem_req_c = 1'b1;
            // a load takes precedence when both were decoded
            dmem_we_c  = wr_q & ~rd_q;
            if (mem.dmem_ready) begin
               if (rd_q) begin
                  state_d = S_WRITEBACK;
               end else begin
                  pc_write_c = 1'b1;
                  state_d    = S_FETCH;
               end
            end else if (wait_q == TMO) begin
               state_d = S_ERROR;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         S_WRITEBACK: begin
            rf_write_c = wb_q;
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d = S_ERROR;
         end
      endcase

      // every change of state starts a fresh wait window
      if (state_d != state_q) begin
         wait_d = 4'd0;
      end
   end

   assign mem.imem_req  = imem_req_c & ~reset;
   assign mem.dmem_req  = dmem_req_c & ~reset;
   assign mem.dmem_we   = dmem_we_c  & ~reset;
   assign ir_write      = ir_write_c & ~reset;
   assign regfile_write = rf_write_c & ~reset;
   assign pc_write      = pc_write_c & ~reset;
   assign pc_sel        = pc_sel_c   & ~reset;

   assign count_d     = pc_write ? count_q + 16'd1 : count_q;
   assign instr_count = count_q;
   assign state       = state_q;
   assign error       = (state_q == S_ERROR);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: directed instruction
// vectors push expected retirements, a monitor checks each pc_write.
module tb_multicycle_sequencer;
   localparam int TMO = 15;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        readmem = 1'b0;
   logic        writemem = 1'b0;
   logic        writereg = 1'b0;
   logic [1:0]  selbrjumpz = 2'd0;
   logic        branch_taken = 1'b0;
   logic        ir_write;
   logic        regfile_write;
   logic        pc_write;
   logic        pc_sel;
   logic [2:0]  state;
   logic        error;
   logic [15:0] instr_count;

   multicycle_sequencer_if mem_if ();

   multicycle_sequencer #(.TIMEOUT(TMO)) dut (
      .clock         (clock),
      .reset         (reset),
      .mem           (mem_if),
      .readmem       (readmem),
      .writemem      (writemem),
      .writereg      (writereg),
      .selbrjumpz    (selbrjumpz),
      .branch_taken  (branch_taken),
      .ir_write      (ir_write),
      .regfile_write (regfile_write),
      .pc_write      (pc_write),
      .pc_sel        (pc_sel),
      .state         (state),
      .error         (error),
      .instr_count   (instr_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      string nm;
      int    st;
      int    ps;
      int    rfw;
      int    lat;
      int    cnt;
      int    start;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [15:0] exp_cnt = 16'd0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // retirement monitor
   always @(negedge clock) begin
      if (!reset && pc_write) begin
         if (sb.size() == 0) begin
            chk("spurious_retire", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.nm, "_state"}, int'(state), e.st);
            chk({e.nm, "_pcsel"}, int'(pc_sel), e.ps);
            chk({e.nm, "_rfw"}, int'(regfile_write), e.rfw);
            chk({e.nm, "_lat"}, cyc - e.start + 1, e.lat);
            chk({e.nm, "_cnt"}, int'(instr_count), e.cnt);
         end
      end
   end

   // entered at posedge+1 while in FETCH; returns the same way
   task automatic issue(
      input string nm,
      input logic rd, input logic wr, input logic wb,
      input logic [1:0] sel, input logic tk,
      input int iw, input int dw,
      input int st, input int ps, input int rfw, input int lat,
      input int we, input int mc);
      int n;
      int mw;
      int mcs;
      int wes;
      sb.push_back('{nm, st, ps, rfw, lat, int'(exp_cnt), cyc});
      exp_cnt = exp_cnt + 16'd1;
      mem_if.imem_ready = 1'b0;
      repeat (iw) begin
         @(posedge clock); #1;
      end
      mem_if.imem_ready = 1'b1;
      readmem = rd;
      writemem = wr;
      writereg = wb;
      selbrjumpz = sel;
      branch_taken = tk;
      @(posedge clock); #1;
      mem_if.imem_ready = 1'b0;
      n = 0;
      mw = 0;
      mcs = 0;
      wes = 0;
      while (state != 3'd0 && n < 60) begin
         if (mem_if.dmem_req) begin
            mcs++;
            wes = wes | int'(mem_if.dmem_we);
         end
         if (state == 3'd3) begin
            mem_if.dmem_ready = (mw >= dw);
            mw++;
         end
         @(posedge clock); #1;
         n++;
      end
      mem_if.dmem_ready = 1'b0;
      readmem = 1'b0;
      writemem = 1'b0;
      writereg = 1'b0;
      selbrjumpz = 2'd0;
      branch_taken = 1'b0;
      chk({nm, "_bound"}, int'(n < 60), 1);
      chk({nm, "_memcyc"}, mcs, mc);
      chk({nm, "_we"}, wes, we);
   endtask

   initial begin
      mem_if.imem_ready = 1'b0;
      mem_if.dmem_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_state", int'(state), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_count", int'(instr_count), 0);
      chk("rst_imem_req", int'(mem_if.imem_req), 0);
      chk("rst_pc_write", int'(pc_write), 0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("rel_state", int'(state), 0);
      chk("rel_imem_req", int'(mem_if.imem_req), 1);

      //     name       rd wr wb sel    tk iw   dw st ps rfw lat we mc
      issue("addi",     0, 0, 1, 2'b00, 0, 0,   0, 4, 0, 1,  4, 0, 0);
      issue("nop",      0, 0, 0, 2'b00, 0, 0,   0, 2, 0, 0,  3, 0, 0);
      issue("br_tk",    0, 0, 0, 2'b01, 1, 0,   0, 2, 1, 0,  3, 0, 0);
      issue("br_nt",    0, 0, 0, 2'b10, 0, 1,   0, 2, 0, 0,  4, 0, 0);
      issue("jmp_pri",  1, 0, 1, 2'b11, 1, 0,   0, 2, 1, 0,  3, 0, 0);
      issue("store",    0, 1, 0, 2'b00, 0, 0,   0, 3, 0, 0,  4, 1, 1);
      issue("store_w2", 0, 1, 0, 2'b00, 0, 0,   2, 3, 0, 0,  6, 1, 3);
      issue("load",     1, 0, 1, 2'b00, 0, 0,   0, 4, 0, 1,  5, 0, 1);
      issue("load_w3",  1, 0, 1, 2'b00, 0, 0,   3, 4, 0, 1,  8, 0, 4);
      issue("ld_st",    1, 1, 1, 2'b00, 0, 0,   0, 4, 0, 1,  5, 0, 1);
      issue("ld_nowb",  1, 0, 0, 2'b00, 0, 0,   0, 4, 0, 0,  5, 0, 1);
      issue("nop_tmo",  0, 0, 0, 2'b00, 0, TMO, 0, 2, 0, 0, 18, 0, 0);

      // fetch timeout into sticky error
      mem_if.imem_ready = 1'b0;
      repeat (TMO + 1) begin
         @(posedge clock); #1;
      end
      chk("tmo_state", int'(state), 7);
      chk("tmo_error", int'(error), 1);
      mem_if.imem_ready = 1'b1;
      repeat (3) begin
         @(posedge clock); #1;
      end
      chk("err_hold_state", int'(state), 7);
      chk("err_hold_error", int'(error), 1);
      chk("err_imem_req", int'(mem_if.imem_req), 0);
      chk("err_ir_write", int'(ir_write), 0);
      chk("err_pc_write", int'(pc_write), 0);
      chk("err_count", int'(instr_count), 12);
      mem_if.imem_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("err_rst_state", int'(state), 0);
      chk("err_rst_error", int'(error), 0);
      chk("err_rst_count", int'(instr_count), 0);
      @(negedge clock);
      reset = 1'b0;
      exp_cnt = 16'd0;
      @(posedge clock); #1;

      // reset during a data-memory wait
      issue("pre_nop",  0, 0, 0, 2'b00, 0, 0,   0, 2, 0, 0,  3, 0, 0);
      mem_if.imem_ready = 1'b1;
      readmem = 1'b1;
      writereg = 1'b1;
      @(posedge clock); #1;
      mem_if.imem_ready = 1'b0;
      repeat (2) begin
         @(posedge clock); #1;
      end
      chk("mrst_pre_state", int'(state), 3);
      chk("mrst_pre_req", int'(mem_if.dmem_req), 1);
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      chk("mrst_dmem_req", int'(mem_if.dmem_req), 0);
      chk("mrst_state", int'(state), 0);
      chk("mrst_count", int'(instr_count), 0);
      readmem = 1'b0;
      writereg = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      exp_cnt = 16'd0;
      @(posedge clock); #1;
      chk("mrst_rel_state", int'(state), 0);
      chk("mrst_rel_req", int'(mem_if.imem_req), 1);

      // counter wrap: preload 0xFFFE, two more retirements
      force dut.count_q = 16'hFFFE;
      @(negedge clock);
      release dut.count_q;
      exp_cnt = 16'hFFFE;
      @(posedge clock); #1;
      issue("wrap_a",   0, 0, 0, 2'b00, 0, 0,   0, 2, 0, 0,  3, 0, 0);
      issue("wrap_b",   0, 0, 0, 2'b00, 0, 0,   0, 2, 0, 0,  3, 0, 0);
      chk("wrap_count", int'(instr_count), 0);

      repeat (2) @(posedge clock);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
